// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access unit: access sizes, FSM states
// and the request legality check.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_EXT,
    ST_MERGE,
    ST_WR,
    ST_ERR
  } state_e;

  // Illegal size, misaligned half/word, or beyond the end of data memory.
  function automatic logic req_is_err(input logic [1:0]  size,
                                      input logic [31:0] addr,
                                      input logic [31:0] limit);
    return (size == SZ_ILL) ||
           ((size == SZ_HALF) && addr[0]) ||
           ((size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
           (addr >= limit);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: pick and extend a byte/half out of a memory word
// for loads, and splice store data into a memory word for sub-word stores.
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_word,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = i_word[{i_lane, 3'b000} +: 8];
    w_half  = i_lane[1] ? i_word[31:16] : i_word[15:0];
    o_load  = i_word;
    o_merge = i_word;
    case (i_size)
      SZ_BYTE: begin
        o_load = {{24{i_signed & w_byte[7]}}, w_byte};
        o_merge[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load = {{16{i_signed & w_half[15]}}, w_half};
        if (i_lane[1]) o_merge[31:16] = i_wdata;
        else           o_merge[15:0]  = i_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit in front of a word-wide data memory.
// Sub-word stores are done as read-modify-write; illegal requests never touch memory.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        dm_read,
  output logic        dm_write,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DM_WORDS);

  state_e      r_state, w_next;
  logic        r_write, r_signed;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata;
  logic        r_rsp_valid, r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic        w_accept, w_err;
  logic [31:0] w_load, w_merge;

  assign req_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;
  assign w_err     = req_is_err(req_size, req_addr, ADDR_LIMIT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_err)                                 w_next = ST_ERR;
          else if (req_write && req_size == SZ_WORD) w_next = ST_WR;
          else                                       w_next = ST_RD;
        end
      end
      ST_RD:   w_next = r_write ? ST_MERGE : ST_EXT;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= SZ_BYTE;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_write  <= req_write;
      r_signed <= req_signed;
      r_size   <= req_size;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
  end

  // Every terminal state reports in the cycle after it; only loads carry data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= (r_state == ST_EXT) || (r_state == ST_MERGE) ||
                     (r_state == ST_WR)  || (r_state == ST_ERR);
      r_rsp_err   <= (r_state == ST_ERR);
      r_rsp_rdata <= (r_state == ST_EXT) ? w_load : '0;
    end
  end

  mem_align u_align (
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_lane   (r_addr[1:0]),
    .i_word   (dm_rdata),
    .i_wdata  (r_wdata[15:0]),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  // Strobes are masked by rst so a reset mid-transaction cannot commit a write.
  assign dm_read  = !rst && (r_state == ST_RD);
  assign dm_write = !rst && ((r_state == ST_MERGE) || (r_state == ST_WR));
  assign dm_addr  = {r_addr[31:2], 2'b00};
  assign dm_wdata = (r_state == ST_WR)    ? r_wdata :
                    (r_state == ST_MERGE) ? w_merge : '0;

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-addressed reference model plus a per-cycle
// response checker, a word-wide memory model, and directed vectors.
module tb_mem_access_unit;

  localparam int DMW = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, dm_read, dm_write;
  logic [31:0] rsp_rdata, dm_addr, dm_wdata;
  logic [31:0] dm_rdata = '0;

  mem_access_unit #(.DM_WORDS(DMW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word-wide data memory with one-cycle read latency, plus strobe counters.
  logic [31:0] dmem [DMW];
  int rd_cnt = 0, wr_cnt = 0;
  initial for (int i = 0; i < DMW; i++) dmem[i] = '0;
  always @(posedge clk) begin
    if (dm_write) begin
      dmem[int'(dm_addr[31:2]) % DMW] <= dm_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (dm_read) begin
      dm_rdata <= dmem[int'(dm_addr[31:2]) % DMW];
      rd_cnt <= rd_cnt + 1;
    end
  end

  // Reference model: memory as bytes; loads/stores move 1, 2 or 4 bytes.
  logic [7:0] mb [4*DMW];
  initial for (int i = 0; i < 4*DMW; i++) mb[i] = '0;

  typedef struct {
    int unsigned due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t expq[$];

  task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd, output int lat);
    int nb;
    nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    err = (sz == 2'b11) || ((a % nb) != 0) || (a >= 32'(4*DMW));
    rd  = '0;
    if (err) lat = 2;
    else if (w) begin
      for (int i = 0; i < nb; i++) mb[int'(a) + i] = wd[8*i +: 8];
      lat = (nb == 4) ? 2 : 3;
    end else begin
      for (int i = 0; i < nb; i++) rd = rd | (32'(mb[int'(a) + i]) << (8*i));
      if (sg && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFF_FFFF << (8*nb));
      lat = 3;
    end
  endtask

  // Per-cycle checker; records the last observed response for literal checks.
  logic        chk_en = 1'b0;
  int unsigned last_cyc = 0;
  logic        last_err = 1'b0;
  logic [31:0] last_rdata = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_wr_exclusive", {31'b0, dm_read & dm_write}, 32'd0);
      if (dm_read || dm_write) chk("dm_addr_aligned", {30'b0, dm_addr[1:0]}, 32'd0);
      if (expq.size() > 0 && expq[0].due == cyc) begin
        chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, expq[0].err});
        chk("rsp_rdata", rsp_rdata, expq[0].rdata);
        last_cyc   = cyc;
        last_err   = rsp_err;
        last_rdata = rsp_rdata;
        void'(expq.pop_front());
      end else begin
        chk("rsp_quiet", {31'b0, rsp_valid}, 32'd0);
      end
    end
  end

  // Called at a negedge. acc = edge number on which the request is taken.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic hold,
                       output int unsigned acc, output logic rv_at_acc);
    int   n = 0;
    logic e;
    logic [31:0] r;
    int   lat;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      errors++; checks++;
      $display("FAIL accept_timeout: req_ready stayed 0 for addr %h", a);
      req_valid = 1'b0; acc = 0; rv_at_acc = 1'b0;
      return;
    end
    rv_at_acc = rsp_valid;
    acc = cyc + 1;
    model(w, sz, sg, a, wd, e, r, lat);
    // Cycle k after acceptance begins at edge acc+k-1.
    expq.push_back('{due: acc + lat - 1, err: e, rdata: r});
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (expq.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (expq.size() != 0) begin
      errors++; checks++;
      $display("FAIL rsp_timeout: %0d responses outstanding", expq.size());
      expq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc, acc2;
    logic rv, rv2;
    int rd0, wr0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_dm_strobes", {30'b0, dm_read, dm_write}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);
    chk_en = 1'b1;

    // Word store then word load
    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, acc, rv); wait_idle();
    chk("lat_word_store", last_cyc - acc + 1, 32'd2);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 0, acc, rv); wait_idle();
    chk("lat_load", last_cyc - acc + 1, 32'd3);
    chk("load_word", last_rdata, 32'hDEADBEEF);

    // Byte store: single RMW
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1, 2'b00, 0, 32'h11, 32'h0000007F, 0, acc, rv); wait_idle();
    chk("lat_byte_store", last_cyc - acc + 1, 32'd3);
    chk("byte_store_reads", rd_cnt - rd0, 32'd1);
    chk("byte_store_writes", wr_cnt - wr0, 32'd1);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 0, acc, rv); wait_idle();
    chk("load_after_byte", last_rdata, 32'hDEAD7FEF);

    // Extension variants
    issue(0, 2'b00, 1, 32'h13, 32'h0, 0, acc, rv); wait_idle();
    chk("lb_signed", last_rdata, 32'hFFFFFFDE);
    issue(0, 2'b00, 0, 32'h13, 32'h0, 0, acc, rv); wait_idle();
    chk("lb_unsigned", last_rdata, 32'h000000DE);
    issue(0, 2'b01, 1, 32'h12, 32'h0, 0, acc, rv); wait_idle();
    chk("lh_signed", last_rdata, 32'hFFFFDEAD);

    // Errors: misaligned word, misaligned half, out of range, illegal size
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(0, 2'b10, 0, 32'h12, 32'h0, 0, acc, rv); wait_idle();
    chk("err_word_mis", {31'b0, last_err}, 32'd1);
    chk("lat_err", last_cyc - acc + 1, 32'd2);
    issue(0, 2'b01, 0, 32'h11, 32'h0, 0, acc, rv); wait_idle();
    chk("err_half_mis", {31'b0, last_err}, 32'd1);
    issue(0, 2'b10, 0, 32'h200, 32'h0, 0, acc, rv); wait_idle();
    chk("err_range", {31'b0, last_err}, 32'd1);
    chk("err_rdata", last_rdata, 32'd0);
    issue(1, 2'b00, 0, 32'h200, 32'h55, 0, acc, rv); wait_idle();
    issue(0, 2'b11, 0, 32'h10, 32'h0, 0, acc, rv); wait_idle();
    chk("err_size", {31'b0, last_err}, 32'd1);
    chk("err_no_strobes", (rd_cnt - rd0) + (wr_cnt - wr0), 32'd0);

    // Reset while in MERGE of a half store
    wr0 = wr_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000FFFF;
    @(negedge clk);               // accepted, now RD
    req_valid = 1'b0;
    @(negedge clk);               // now MERGE
    chk("merge_reached", {31'b0, dm_write}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_masks_write", {31'b0, dm_write}, 32'd0);
    chk("rst_ready_low", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("ready_after_rst_fall", {31'b0, req_ready}, 32'd1);
    chk("rst_no_write", wr_cnt - wr0, 32'd0);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 0, acc, rv); wait_idle();
    chk("mem_kept_after_rst", last_rdata, 32'hDEAD7FEF);

    // Upper half store ignores wdata[31:16]; boundary word at end of memory
    issue(1, 2'b01, 0, 32'h12, 32'hAAAA1234, 0, acc, rv); wait_idle();
    issue(0, 2'b00, 0, 32'h12, 32'h0, 0, acc, rv); wait_idle();
    chk("lb_after_sh", last_rdata, 32'h00000034);
    issue(0, 2'b01, 1, 32'h10, 32'h0, 0, acc, rv); wait_idle();
    chk("lh_pos", last_rdata, 32'h00007FEF);
    issue(1, 2'b10, 0, 32'h1FC, 32'h80000001, 0, acc, rv); wait_idle();
    issue(0, 2'b00, 1, 32'h1FF, 32'h0, 0, acc, rv); wait_idle();
    chk("lb_top_signed", last_rdata, 32'hFFFFFF80);
    issue(0, 2'b01, 0, 32'h1FE, 32'h0, 0, acc, rv); wait_idle();
    chk("lh_top_unsigned", last_rdata, 32'h00008000);

    // Back-to-back loads with req_valid held
    issue(0, 2'b10, 0, 32'h10, 32'h0, 1, acc, rv);
    issue(0, 2'b00, 1, 32'h11, 32'h0, 0, acc2, rv2);
    chk("b2b_rsp_at_accept", {31'b0, rv2}, 32'd1);
    chk("b2b_gap", acc2 - acc, 32'd3);
    wait_idle();
    chk("b2b_second", last_rdata, 32'h0000007F);

    // Memory image matches the model
    for (int w = 0; w < DMW; w += 127)
      chk("mem_image", dmem[w], {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]});
    chk("mem_word4", dmem[4], 32'h12347FEF);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DM_WORDS, default 128: number of 32-bit words in the data memory served; addresses at or above 4*DM_WORDS are out of range.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  upstream request present.
REQ-005 req_ready  out  1  unit can accept a request.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_signed  in  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_err  out  1  request rejected; qualified by rsp_valid.
REQ-013 rsp_rdata  out  32  load result; 0 for stores and errors.
REQ-014 dm_read, dm_write  out  1 each  data-memory strobes; never both high.
REQ-015 dm_addr  out  32  word-aligned address to data memory (low two bits 0).
REQ-016 dm_wdata  out  32  full word to write.
REQ-017 dm_rdata  in  32  data-memory word, valid the cycle after dm_read is sampled.

Function
REQ-018 The unit SHALL hold at most one request; req_ready=1 only in IDLE, and a request is accepted on a posedge with req_valid&req_ready.
REQ-019 FSM states SHALL be IDLE, RD, EXT, MERGE, WR, ERR.
REQ-020 Acceptance SHALL route: error -> ERR; word store -> WR; load or sub-word store -> RD.
REQ-021 Error: req_size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr >= 4*DM_WORDS.
REQ-022 RD SHALL drive dm_read=1 for exactly one cycle, then go to EXT (load) or MERGE (sub-word store).
REQ-023 EXT SHALL select the addressed lane from dm_rdata (little-endian: byte k = bits 8k+7:8k, half h = bits 16h+15:16h), extend per req_signed, and register it into rsp_rdata.
REQ-024 MERGE SHALL drive dm_write=1 for one cycle with dm_rdata, the addressed lane replaced by the low byte/half of req_wdata.
REQ-025 WR SHALL drive dm_write=1 for one cycle with req_wdata.
REQ-026 ERR SHALL perform no memory access.
REQ-027 EXT, MERGE, WR and ERR SHALL each return to IDLE and set rsp_valid=1 for the following cycle; rsp_err=1 only from ERR.
REQ-028 Latency, acceptance edge to rsp_valid high: load 3 cycles, sub-word store 3, word store 2, error 2.
REQ-029 A new request SHALL be acceptable in the same cycle rsp_valid is high.
REQ-030 dm_read, dm_write, dm_addr and dm_wdata SHALL decode from state and captured request registers only, never from live req_* inputs.

Reset
REQ-031 On rst, the next state SHALL be IDLE, the captured request SHALL be discarded, and rsp_valid, rsp_err, rsp_rdata, dm_read and dm_write SHALL be 0 in the cycle after the edge.
REQ-032 req_ready SHALL be 0 while rst is high.
REQ-033 Reset during RD, EXT or MERGE SHALL suppress any pending write and any response; memory contents are untouched.

Structure
REQ-034 Package mem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-035 A combinational sub-module mem_align SHALL perform lane extract/extend and lane merge; the FSM lives in mem_access_unit.

Verification
REQ-036 Word store 0xDEADBEEF @0x10, then unsigned word load @0x10 -> rsp_rdata=0xDEADBEEF; store rsp at +2 cycles, load rsp at +3.
REQ-037 Byte store 0x7F @0x11 -> exactly one dm_read and one dm_write; a following word load @0x10 returns 0xDEAD7FEF.
REQ-038 Loads on 0xDEAD7FEF: signed byte @0x13 -> 0xFFFFFFDE; unsigned byte @0x13 -> 0x000000DE; signed half @0x12 -> 0xFFFFDEAD.
REQ-039 Word load @0x12, half load @0x11 and word load @0x200 -> rsp_err=1, rsp_rdata=0, no DM strobes, rsp at +2 cycles.
REQ-040 rst pulsed while in MERGE of half store 0xFFFF @0x10 -> no dm_write, no rsp_valid, word load @0x10 still returns 0xDEAD7FEF; req_ready=1 one cycle after rst falls.
REQ-041 Back-to-back loads with req_valid held high -> second request accepted in the cycle the first rsp_valid is high.
